// File: rtl/store_buffer.sv
// Purpose: in-order store buffer between core and dmem with load lookup/forwarding.
// Latency: a pushed store is drainable the following cycle; lookup is combinational.
// Backpressure: st_ready drops when all DEPTH entries are full; drain stalls while mem_busy.
//
// Ports:
//   clk, reset         core clock; asynchronous active-low reset
//   st_valid/st_ready  store handshake carrying st_addr, st_data, st_be
//   ld_valid, ld_addr, ld_be
//                      load lookup; the result is returned on fwd_hit, fwd_data
//                      and ld_conflict in the same cycle
//   mem_busy           dmem port taken by a core load this cycle; no drain
//   mem_we, mem_addr, mem_wd
//                      dmem write port, always driven from the head entry
//   empty, count       occupancy
// Build option: define STORE_BUFFER_FWD_EN to enable byte-lane store-to-load
// forwarding. Without it every matching load reports a conflict.

module store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       st_valid,
    output logic                       st_ready,
    input  logic [31:0]                st_addr,
    input  logic [31:0]                st_data,
    input  logic [3:0]                 st_be,
    input  logic                       ld_valid,
    input  logic [31:0]                ld_addr,
    input  logic [3:0]                 ld_be,
    output logic                       fwd_hit,
    output logic [31:0]                fwd_data,
    output logic                       ld_conflict,
    input  logic                       mem_busy,
    output logic [3:0]                 mem_we,
    output logic [31:0]                mem_addr,
    output logic [31:0]                mem_wd,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [29:0] addr;   // word address
        logic [31:0] data;
        logic [3:0]  be;
    } entry_t;

    entry_t          ent_q [DEPTH];
    logic [DEPTH-1:0] vld_q;
    logic [PW-1:0]   head_q;
    logic [PW-1:0]   tail_q;
    logic [CW-1:0]   count_q;

    logic push;
    logic drain;

    // Byte-offset bits of both addresses are meaningless for word matching.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{st_addr[1:0], ld_addr[1:0]};

    // st_ready looks only at registered occupancy: a drain this cycle does not
    // open a slot until the next cycle, which keeps st_ready off the mem_busy path.
    assign st_ready = (count_q != CW'(DEPTH));
    assign push     = st_valid && st_ready && (st_be != 4'b0000);
    assign drain    = (count_q != '0) && !mem_busy;

    assign empty    = (count_q == '0);
    assign count    = count_q;

    assign mem_we   = drain ? ent_q[head_q].be : 4'b0000;
    assign mem_addr = {ent_q[head_q].addr, 2'b00};
    assign mem_wd   = ent_q[head_q].data;

    // Payload storage carries no reset; validity is tracked separately.
    always_ff @(posedge clk) begin
        if (push) begin
            ent_q[tail_q] <= '{addr: st_addr[31:2], data: st_data, be: st_be};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            vld_q   <= '0;
        end else begin
            // A push never targets the head slot while it drains: tail == head
            // only when empty (no drain) or full (no push).
            if (push) begin
                tail_q        <= tail_q + PW'(1);
                vld_q[tail_q] <= 1'b1;
            end
            if (drain) begin
                head_q        <= head_q + PW'(1);
                vld_q[head_q] <= 1'b0;
            end
            count_q <= count_q + CW'(push) - CW'(drain);
        end
    end

    // Lookup walks oldest to youngest so younger entries overwrite older bytes.
    // The draining head is still valid here, so it stays visible this cycle.
    logic          any_match;
    logic [PW-1:0] idx;
`ifdef STORE_BUFFER_FWD_EN
    logic [3:0]    cov;
    logic [31:0]   fdat;
`endif

    always_comb begin
        any_match = 1'b0;
        idx       = '0;
`ifdef STORE_BUFFER_FWD_EN
        cov       = 4'b0000;
        fdat      = '0;
`endif
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_q + PW'(k);
            if (vld_q[idx] && (ent_q[idx].addr == ld_addr[31:2])) begin
                any_match = 1'b1;
`ifdef STORE_BUFFER_FWD_EN
                for (int b = 0; b < 4; b++) begin
                    if (ent_q[idx].be[b]) begin
                        cov[b]         = 1'b1;
                        fdat[8*b +: 8] = ent_q[idx].data[8*b +: 8];
                    end
                end
`endif
            end
        end
    end

`ifdef STORE_BUFFER_FWD_EN
    assign fwd_hit     = ld_valid && ((cov & ld_be) == ld_be);
    assign fwd_data    = ld_valid ? fdat : 32'h0;
    assign ld_conflict = ld_valid && any_match && !fwd_hit;
`else
    logic unused_ld_be;
    assign unused_ld_be = ^ld_be;
    assign fwd_hit      = 1'b0;
    assign fwd_data     = 32'h0;
    assign ld_conflict  = ld_valid && any_match;
`endif

endmodule
